// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue in front of a valid/ready imem port.
// Redirects flush buffered words and squash responses that memory still owes.
module if_prefetch_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            BranchTaken,
    input  logic            Jal,
    input  logic            Jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] RD1,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] PC,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC_plus4
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    // Squashed responses can pile up across back-to-back redirects, so give headroom.
    localparam int unsigned DW = CW + 2;

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   total;
    logic [DW-1:0]   drop_cnt;

    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];

    logic            redirect;
    logic            req_fire;
    logic            rsp_take;
    logic            pop;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic [PW-1:0]   wr_idx;
    logic [PW-1:0]   tag_idx;

    // Jal and BranchTaken share a target, so only Jalr needs to override it.
    always_comb begin
        // NOTE: defaults come first so no path through the block leaves a latch.
        target_sum = br_pc + ImmExt;
        if (Jalr) begin
            target_sum = RD1 + ImmExt;
        end
        target = target_sum & ~XLEN'(3);
    end

    assign redirect       = BranchTaken | Jal | Jalr;
    assign total          = count + outstanding;
    assign imem_req_valid = reset_n & ~redirect & (total < CW'(FIFO_DEPTH));
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_take       = imem_rsp_valid & (drop_cnt == '0);
    assign if_valid       = (count != '0);
    assign pop            = if_valid & if_ready;

    // Ring order: head, buffered words, then tags still waiting for their data.
    assign wr_idx  = rd_ptr + count[PW-1:0];
    assign tag_idx = rd_ptr + total[PW-1:0];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every reader in this edge sees pre-edge state.
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            fetch_pc    <= target;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (imem_rsp_valid && !rsp_take) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            count       <= count + CW'(rsp_take) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // NOTE: payload storage has no reset; if_valid qualifies every read of it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[tag_idx] <= fetch_pc;
        end
        if (rsp_take && reset_n && !redirect) begin
            instr_mem[wr_idx] <= imem_rsp_data;
        end
    end

    assign PC       = if_valid ? pc_mem[rd_ptr] : '0;
    assign Instr    = if_valid ? instr_mem[rd_ptr] : '0;
    assign PC_plus4 = if_valid ? pc_mem[rd_ptr] + XLEN'(4) : '0;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: a memory model answers fetches in order,
// stimulus queues the PCs decode must see, and a monitor checks every handshake.
module tb_if_prefetch_stage;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        BranchTaken, Jal, Jalr;
    logic [31:0] br_pc, ImmExt, RD1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid, if_ready;
    logic [31:0] PC, Instr, PC_plus4;

    logic        req_valid_w;
    logic [31:0] addr_w;
    logic        rsp_valid_w = 1'b0;
    logic [31:0] rsp_data_w = '0;
    logic        if_valid_w, if_ready_w;
    logic [31:0] pc_w, instr_w, pc_plus4_w;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_w;
    logic        acc_w = 1'b0;
    logic [31:0] acc_addr_w = '0;

    if_prefetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .BranchTaken(BranchTaken), .Jal(Jal), .Jalr(Jalr),
        .br_pc(br_pc), .ImmExt(ImmExt), .RD1(RD1),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready),
        .PC(PC), .Instr(Instr), .PC_plus4(PC_plus4)
    );

    if_prefetch_stage #(.XLEN(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n),
        .BranchTaken(1'b0), .Jal(1'b0), .Jalr(1'b0),
        .br_pc(32'h0), .ImmExt(32'h0), .RD1(32'h0),
        .imem_req_valid(req_valid_w), .imem_req_ready(1'b1), .imem_addr(addr_w),
        .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
        .if_valid(if_valid_w), .if_ready(if_ready_w),
        .PC(pc_w), .Instr(instr_w), .PC_plus4(pc_plus4_w)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main memory: in-order responses lat cycles after accept, optional random ready.
    always @(negedge clk) begin
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
            pend.delete(0);
        end
        imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        if (!reset_n) begin
            pend.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_addr, due: cyc + lat});
            acc_cnt++;
        end
    end

    // Memory for the wrap instance: always ready, one-cycle latency.
    always @(negedge clk) begin
        rsp_valid_w = acc_w;
        rsp_data_w  = instr_of(acc_addr_w);
        #2;
        acc_w      = reset_n && req_valid_w;
        acc_addr_w = addr_w;
    end

    // Monitor: every decode handshake must match the next queued PC.
    always @(negedge clk) begin
        #2;
        if (reset_n && if_valid && if_ready && !(BranchTaken || Jal || Jalr)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got PC %h, want no delivery (cycle %0d)", PC, cyc);
            end else begin
                exp_pc = exp_q.pop_front();
                check("pc", PC, exp_pc);
                check("instr", Instr, instr_of(exp_pc));
                check("pc_plus4", PC_plus4, exp_pc + 32'd4);
            end
        end
        if (reset_n && if_valid_w && if_ready_w) begin
            if (exp_w.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop_w: got PC %h, want no delivery (cycle %0d)", pc_w, cyc);
            end else begin
                exp_pc_w = exp_w.pop_front();
                check("pc_w", pc_w, exp_pc_w);
                check("instr_w", instr_w, instr_of(exp_pc_w));
                check("pc_plus4_w", pc_plus4_w, exp_pc_w + 32'd4);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        if_ready   = 1'b0;
        if_ready_w = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push_seq(input bit w, input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            if (w) exp_w.push_back(start + 32'(4 * i));
            else   exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic drain(input bit w, output int cycles);
        cycles = 0;
        while ((w ? exp_w.size() : exp_q.size()) != 0 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        if (w) begin
            check("drain_w", 32'(exp_w.size()), 32'h0);
            if_ready_w = 1'b0;
            exp_w.delete();
        end else begin
            check("drain", 32'(exp_q.size()), 32'h0);
            if_ready = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        BranchTaken = 1'b0; Jal = 1'b0; Jalr = 1'b0;
        br_pc = '0; ImmExt = '0; RD1 = '0;
        if_ready = 1'b0; if_ready_w = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_bit("rst_if_valid", if_valid, 1'b0);
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pc_plus4", PC_plus4, 32'h0);
        check_bit("rst_req_valid_w", req_valid_w, 1'b0);

        // 1: latency 1, decode always ready -> 2-cycle fill then one per cycle
        lat = 1;
        do_reset();
        if_ready = 1'b1;
        push_seq(0, 32'h0, 8);
        #2;
        check_bit("t1_req_valid", imem_req_valid, 1'b1);
        check("t1_addr", imem_addr, 32'h0);
        check_bit("t1_if_valid", if_valid, 1'b0);
        drain(0, n);
        check("t1_cycles", 32'(n), 32'd10);

        // 2: decode stalled -> exactly FIFO_DEPTH accepts, head frozen
        do_reset();
        acc_cnt = 0;
        repeat (10) @(negedge clk);
        #2;
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check_bit("t2_req_valid", imem_req_valid, 1'b0);
        check_bit("t2_if_valid", if_valid, 1'b1);
        check("t2_pc", PC, 32'h0);
        check("t2_instr", Instr, instr_of(32'h0));
        check("t2_pc_plus4", PC_plus4, 32'h4);
        @(negedge clk);
        push_seq(0, 32'h0, 8);
        if_ready = 1'b1;
        drain(0, n);

        // 3: latency 3, Jal while 0x14/0x18/0x1C are in flight
        lat = 3;
        do_reset();
        Jal = 1'b1; br_pc = 32'h0; ImmExt = 32'h14;
        #2;
        check_bit("t3_req_in_redirect", imem_req_valid, 1'b0);
        @(negedge clk);
        Jal = 1'b0;
        #2;
        check("t3_first_addr", imem_addr, 32'h14);
        repeat (3) @(negedge clk);
        Jal = 1'b1; br_pc = 32'h10; ImmExt = 32'h20;
        #2;
        check_bit("t3_rsp_in_redirect", imem_rsp_valid, 1'b1);
        check_bit("t3_req_blocked", imem_req_valid, 1'b0);
        @(negedge clk);
        Jal = 1'b0;
        #2;
        check_bit("t3_if_valid_after", if_valid, 1'b0);
        check_bit("t3_req_valid_after", imem_req_valid, 1'b1);
        check("t3_target_addr", imem_addr, 32'h30);
        @(negedge clk);
        push_seq(0, 32'h30, 8);
        if_ready = 1'b1;
        drain(0, n);

        // 4: full queue, Jalr+Jal together -> Jalr target with low bits cleared
        lat = 1;
        do_reset();
        repeat (6) @(negedge clk);
        Jalr = 1'b1; Jal = 1'b1; RD1 = 32'h103; ImmExt = 32'h4; br_pc = 32'h200;
        #2;
        check_bit("t4_if_valid_in_redirect", if_valid, 1'b1);
        check_bit("t4_req_blocked", imem_req_valid, 1'b0);
        @(negedge clk);
        Jalr = 1'b0; Jal = 1'b0;
        #2;
        check_bit("t4_if_valid_after", if_valid, 1'b0);
        check("t4_jalr_addr", imem_addr, 32'h104);
        @(negedge clk);
        push_seq(0, 32'h104, 8);
        if_ready = 1'b1;
        drain(0, n);
        // BranchTaken with a negative, misaligned offset
        @(negedge clk);
        BranchTaken = 1'b1; br_pc = 32'h100; ImmExt = 32'hFFFF_FFFA;
        @(negedge clk);
        BranchTaken = 1'b0;
        #2;
        check("t4_branch_addr", imem_addr, 32'hF8);
        check_bit("t4_branch_if_valid", if_valid, 1'b0);
        @(negedge clk);
        push_seq(0, 32'hF8, 6);
        if_ready = 1'b1;
        drain(0, n);

        // 5: RESET_PC near the top of the address space wraps to 0
        do_reset();
        if_ready_w = 1'b1;
        push_seq(1, WRAP_PC, 4);
        #2;
        check_bit("t5_req_valid", req_valid_w, 1'b1);
        check("t5_first_addr", addr_w, WRAP_PC);
        drain(1, n);

        // 6: reset with a full queue and random memory ready
        rand_ready = 1'b1;
        lat = 2;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (imem_req_valid && n < 100);
        check_bit("t6_full", imem_req_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        check_bit("t6_req_in_reset", imem_req_valid, 1'b0);
        @(negedge clk);
        #2;
        check_bit("t6_if_valid", if_valid, 1'b0);
        check_bit("t6_req_valid", imem_req_valid, 1'b0);
        check("t6_pc", PC, 32'h0);
        check("t6_pc_plus4", PC_plus4, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        check_bit("t6_req_after", imem_req_valid, 1'b1);
        check("t6_addr_after", imem_addr, 32'h0);
        @(negedge clk);
        push_seq(0, 32'h0, 6);
        if_ready = 1'b1;
        drain(0, n);
        rand_ready = 1'b0;

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
